// File: rtl/nios_mul_cell_pipe.sv
// Pipelined WIDTH x WIDTH multiply cell for the Nios II custom datapath.
// Four registered unsigned half-products, sign-corrected in stage 2, then optional delay stages.
module nios_mul_cell_pipe #(
  parameter int               WIDTH        = 32,
  parameter int               LATENCY      = 2,
  parameter logic [WIDTH-1:0] RESET_RESULT = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ena,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int HALF = WIDTH / 2;

  logic [LATENCY:1]   r_vld;
  logic [WIDTH-1:0]   r_pp_ll, r_pp_lh, r_pp_hl, r_pp_hh;
  logic [WIDTH-1:0]   r_a, r_b;
  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_word [2:LATENCY];

  logic [WIDTH-1:0]   w_al, w_ah, w_bl, w_bh;
  logic [2*WIDTH-1:0] w_mid, w_p;
  logic [WIDTH-1:0]   w_word;

  assign w_al = {{HALF{1'b0}}, src1[HALF-1:0]};
  assign w_ah = {{HALF{1'b0}}, src1[WIDTH-1:HALF]};
  assign w_bl = {{HALF{1'b0}}, src2[HALF-1:0]};
  assign w_bh = {{HALF{1'b0}}, src2[WIDTH-1:HALF]};

  // Signed operands are handled as unsigned products minus the sign-weighted other operand.
  always_comb begin
    w_mid = {{WIDTH{1'b0}}, r_pp_lh} + {{WIDTH{1'b0}}, r_pp_hl};
    w_p   = {{WIDTH{1'b0}}, r_pp_ll} + (w_mid << HALF) + {r_pp_hh, {WIDTH{1'b0}}};
    if ((r_op == 2'b01 || r_op == 2'b10) && r_a[WIDTH-1])
      w_p = w_p - {r_b, {WIDTH{1'b0}}};
    if (r_op == 2'b01 && r_b[WIDTH-1])
      w_p = w_p - {r_a, {WIDTH{1'b0}}};
    w_word = (r_op == 2'b00) ? w_p[WIDTH-1:0] : w_p[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld   <= '0;
      r_pp_ll <= '0;
      r_pp_lh <= '0;
      r_pp_hl <= '0;
      r_pp_hh <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      for (int i = 2; i <= LATENCY; i++)
        r_word[i] <= (i == LATENCY) ? RESET_RESULT : '0;
    end else begin
      // flush wins over the freeze so a stalled pipe can still be emptied
      if (flush)
        r_vld <= '0;
      else if (ena)
        r_vld <= {r_vld[LATENCY-1:1], in_valid};

      if (ena && !flush) begin
        if (in_valid) begin
          r_pp_ll <= w_al * w_bl;
          r_pp_lh <= w_al * w_bh;
          r_pp_hl <= w_ah * w_bl;
          r_pp_hh <= w_ah * w_bh;
          r_a     <= src1;
          r_b     <= src2;
          r_op    <= op;
        end
        if (r_vld[1])
          r_word[2] <= w_word;
        for (int i = 3; i <= LATENCY; i++)
          if (r_vld[i-1])
            r_word[i] <= r_word[i-1];
      end
    end
  end

  assign out_valid = r_vld[LATENCY];
  assign result    = r_word[LATENCY];
  assign busy      = |r_vld[LATENCY-1:1];

endmodule

// File: tb/tb_nios_mul_cell_pipe.sv
// Directed bench for nios_mul_cell_pipe: a LATENCY=2 and a LATENCY=4 instance share stimulus.
module tb_nios_mul_cell_pipe;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ena, flush, in_valid;
  logic [1:0]  op;
  logic [31:0] src1, src2;
  logic        out_valid, busy, ov4, busy4;
  logic [31:0] result, res4;

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0]  q_op  [8];
  logic [31:0] q_a   [8];
  logic [31:0] q_b   [8];
  logic [31:0] q_exp [8];

  always #5 clk = ~clk;

  nios_mul_cell_pipe #(.WIDTH(32), .LATENCY(2), .RESET_RESULT(32'h0)) dut (
    .clk(clk), .reset_n(reset_n), .ena(ena), .flush(flush), .in_valid(in_valid),
    .op(op), .src1(src1), .src2(src2),
    .out_valid(out_valid), .result(result), .busy(busy)
  );

  nios_mul_cell_pipe #(.WIDTH(32), .LATENCY(4), .RESET_RESULT(32'hA5A5A5A5)) dut4 (
    .clk(clk), .reset_n(reset_n), .ena(ena), .flush(flush), .in_valid(in_valid),
    .op(op), .src1(src1), .src2(src2),
    .out_valid(ov4), .result(res4), .busy(busy4)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    op       = o;
    src1     = a;
    src2     = b;
  endtask

  // Streams n queued ops back-to-back through the LATENCY=2 instance.
  task automatic stream(input string tag, input int n);
    for (int c = 0; c < n + 2; c++) begin
      if (c < n) drive(q_op[c], q_a[c], q_b[c]);
      else in_valid = 1'b0;
      step();
      if (c == 0) chk({tag, "_busy"}, busy, 1'b1);
      if (c >= 1) begin
        chk({tag, "_ov"}, out_valid, (c - 1 < n));
        if (c - 1 < n) chk({tag, "_res"}, result, q_exp[c-1]);
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    reset_n  = 1'b0;
    ena      = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    op       = 2'b00;
    src1     = '0;
    src2     = '0;
    #12;
    chk("rst_ov", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_res", result, 32'h0);
    chk("rst_res4", res4, 32'hA5A5A5A5);
    reset_n = 1'b1;
    ena     = 1'b1;
    step();

    // 1: 0xFFFF squared, low and high word
    q_op[0] = 2'b00; q_a[0] = 32'h0000FFFF; q_b[0] = 32'h0000FFFF; q_exp[0] = 32'hFFFE0001;
    stream("t1_mul", 1);
    q_op[0] = 2'b11; q_exp[0] = 32'h00000000;
    stream("t1_mulxuu", 1);

    // 2: all-ones operands under every signedness
    for (int i = 0; i < 4; i++) begin
      q_a[i] = 32'hFFFFFFFF;
      q_b[i] = 32'hFFFFFFFF;
    end
    q_op[0] = 2'b01; q_exp[0] = 32'h00000000;
    q_op[1] = 2'b10; q_exp[1] = 32'hFFFFFFFF;
    q_op[2] = 2'b11; q_exp[2] = 32'hFFFFFFFE;
    q_op[3] = 2'b00; q_exp[3] = 32'h00000001;
    stream("t2", 4);

    // 3: carry into the high word, and most-negative signed operand
    q_op[0] = 2'b11; q_a[0] = 32'h00010000; q_b[0] = 32'h00010000; q_exp[0] = 32'h00000001;
    q_op[1] = 2'b00; q_a[1] = 32'h00010000; q_b[1] = 32'h00010000; q_exp[1] = 32'h00000000;
    q_op[2] = 2'b01; q_a[2] = 32'h80000000; q_b[2] = 32'h00000002; q_exp[2] = 32'hFFFFFFFF;
    stream("t3", 3);

    // 4: three-cycle stall after the second accept
    drive(2'b00, 32'd3, 32'd5);
    step();
    chk("t4_ov0", out_valid, 1'b0);
    drive(2'b00, 32'd7, 32'd9);
    step();
    chk("t4_ov1", out_valid, 1'b1);
    chk("t4_res1", result, 32'd15);
    ena = 1'b0;
    drive(2'b11, 32'hFFFFFFFF, 32'd2);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_stall_ov", out_valid, 1'b1);
      chk("t4_stall_res", result, 32'd15);
      chk("t4_stall_busy", busy, 1'b1);
    end
    ena = 1'b1;
    step();
    chk("t4_res2", result, 32'd63);
    drive(2'b10, 32'hFFFFFFFE, 32'd3);
    step();
    chk("t4_ov3", out_valid, 1'b1);
    chk("t4_res3", result, 32'h00000001);
    in_valid = 1'b0;
    step();
    chk("t4_ov4", out_valid, 1'b1);
    chk("t4_res4", result, 32'hFFFFFFFF);
    step();
    chk("t4_ov_end", out_valid, 1'b0);
    chk("t4_res_hold", result, 32'hFFFFFFFF);
    for (int i = 0; i < 3; i++) step();
    chk("t4_l4_res", res4, 32'hFFFFFFFF);
    chk("t4_l4_ov", ov4, 1'b0);

    // 5: flush on the LATENCY=4 instance, with and without ena
    drive(2'b00, 32'd2, 32'd2);
    step();
    drive(2'b00, 32'd3, 32'd3);
    step();
    flush = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("t5_busy", busy4, 1'b0);
    chk("t5_ov", ov4, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5_ov_late", ov4, 1'b0);
    end
    chk("t5_res", res4, 32'hFFFFFFFF);
    drive(2'b00, 32'd4, 32'd4);
    step();
    in_valid = 1'b0;
    ena      = 1'b0;
    flush    = 1'b1;
    step();
    chk("t5_frz_busy", busy4, 1'b0);
    flush = 1'b0;
    ena   = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("t5_frz_ov", ov4, 1'b0);
    chk("t5_frz_res", res4, 32'hFFFFFFFF);

    // 6: async reset mid-operation, then a clean op
    drive(2'b00, 32'd3, 32'd4);
    step();
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("t6_ov", out_valid, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_res", result, 32'h0);
    chk("t6_res4", res4, 32'hA5A5A5A5);
    #2 reset_n = 1'b1;
    step();
    chk("t6_no_late", out_valid, 1'b0);
    drive(2'b00, 32'd6, 32'd7);
    step();
    in_valid = 1'b0;
    chk("t6_ov_pre", out_valid, 1'b0);
    chk("t6_busy_post", busy, 1'b1);
    step();
    chk("t6_ov_new", out_valid, 1'b1);
    chk("t6_res_new", result, 32'd42);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
